// File: rtl/decoder_scan.sv
// decoder_scan: N-to-2**N one-hot decoder with a DIRECT mode (decode select
// code a) and a SCAN mode (walk the one-hot bit across all outputs).
// Optional feature macro: DECODER_SCAN_DWELL_EN adds the dwell port, the
// captured-dwell register and the dwell counter, so each SCAN step can be
// held for dwell+1 cycles. Without it SCAN steps every cycle.
module decoder_scan #(
    parameter int N  = 3,
    parameter int DW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      a,
    input  logic              a_valid,
    output logic              a_ready,
`ifdef DECODER_SCAN_DWELL_EN
    input  logic [DW-1:0]     dwell,
`endif
    output logic [2**N-1:0]   y,
    output logic              y_valid,
    output logic              scan_wrap
);

    localparam int W = 2**N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [W-1:0]   y_r;
    logic [W-1:0]   y_nxt_s;
    logic           y_valid_r;
    logic           y_valid_nxt_s;
    logic           wrap_r;
    logic           wrap_nxt_s;
    logic [N-1:0]   idx_r;
    logic [N-1:0]   idx_nxt_s;
    logic           step_s;

`ifdef DECODER_SCAN_DWELL_EN
    logic [DW-1:0]  cnt_r;
    logic [DW-1:0]  cnt_nxt_s;
    logic [DW-1:0]  cap_r;
    logic [DW-1:0]  cap_nxt_s;
`else
    // Without the dwell feature every step behaves as a zero dwell.
    localparam logic [DW-1:0] FIXED_DWELL = '0;
`endif

    // One-hot decode of a select code; the result always has exactly one bit set.
    function automatic logic [W-1:0] decode_f(input logic [N-1:0] code);
        logic [W-1:0] one_v;
        one_v = {{(W-1){1'b0}}, 1'b1};
        return one_v << code;
    endfunction

    assign a_ready   = (state_r == DIRECT);
    assign y         = y_r;
    assign y_valid   = y_valid_r;
    assign scan_wrap = wrap_r;

    // Decide whether the current SCAN index has been shown long enough.
    always_comb begin
`ifdef DECODER_SCAN_DWELL_EN
        step_s = (cnt_r == cap_r);
`else
        step_s = (FIXED_DWELL == '0);
`endif
    end

    // Next state follows en/mode directly from any state.
    always_comb begin
        if (!en) begin
            state_nxt_s = IDLE;
        end else if (mode) begin
            state_nxt_s = SCAN;
        end else begin
            state_nxt_s = DIRECT;
        end
    end

    // Next values of the output, index and dwell registers.
    always_comb begin
        y_nxt_s       = y_r;
        y_valid_nxt_s = y_valid_r;
        wrap_nxt_s    = 1'b0;
        idx_nxt_s     = idx_r;
`ifdef DECODER_SCAN_DWELL_EN
        cnt_nxt_s     = cnt_r;
        cap_nxt_s     = cap_r;
`endif
        case (state_nxt_s)
            IDLE: begin
                y_nxt_s       = '0;
                y_valid_nxt_s = 1'b0;
                idx_nxt_s     = '0;
`ifdef DECODER_SCAN_DWELL_EN
                cnt_nxt_s     = '0;
                cap_nxt_s     = '0;
`endif
            end
            DIRECT: begin
                idx_nxt_s = '0;
`ifdef DECODER_SCAN_DWELL_EN
                cnt_nxt_s = '0;
                cap_nxt_s = '0;
`endif
                // Entry edge clears the output; a code offered then is dropped
                // because a_ready was still low.
                if (state_r != DIRECT) begin
                    y_nxt_s       = '0;
                    y_valid_nxt_s = 1'b0;
                end else if (a_valid) begin
                    y_nxt_s       = decode_f(a);
                    y_valid_nxt_s = 1'b1;
                end else begin
                    y_nxt_s       = y_r;
                    y_valid_nxt_s = y_valid_r;
                end
            end
            SCAN: begin
                if (state_r != SCAN) begin
                    idx_nxt_s     = '0;
                    y_nxt_s       = decode_f(N'(0));
                    y_valid_nxt_s = 1'b1;
`ifdef DECODER_SCAN_DWELL_EN
                    cnt_nxt_s     = '0;
                    cap_nxt_s     = dwell;
`endif
                end else if (step_s) begin
                    idx_nxt_s     = idx_r + N'(1);
                    y_nxt_s       = decode_f(idx_r + N'(1));
                    y_valid_nxt_s = 1'b1;
                    wrap_nxt_s    = &idx_r;
`ifdef DECODER_SCAN_DWELL_EN
                    cnt_nxt_s     = '0;
                    cap_nxt_s     = dwell;
`endif
                end else begin
                    y_valid_nxt_s = 1'b1;
`ifdef DECODER_SCAN_DWELL_EN
                    cnt_nxt_s     = cnt_r + DW'(1);
`endif
                end
            end
            default: begin
                y_nxt_s       = '0;
                y_valid_nxt_s = 1'b0;
                idx_nxt_s     = '0;
`ifdef DECODER_SCAN_DWELL_EN
                cnt_nxt_s     = '0;
                cap_nxt_s     = '0;
`endif
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            y_r       <= '0;
            y_valid_r <= 1'b0;
            wrap_r    <= 1'b0;
            idx_r     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            y_r       <= y_nxt_s;
            y_valid_r <= y_valid_nxt_s;
            wrap_r    <= wrap_nxt_s;
            idx_r     <= idx_nxt_s;
        end
    end

`ifdef DECODER_SCAN_DWELL_EN
    // Dwell counter and captured-dwell registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            cap_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
            cap_r <= cap_nxt_s;
        end
    end
`endif

endmodule
